// File: rtl/interrupt_arbiter_if.sv
// rtl/interrupt_arbiter_if.sv - request/acknowledge bus between devices, CPU and interrupt_arbiter
interface interrupt_arbiter_if;
    logic [3:0]  req;
    logic        mask_we;
    logic [3:0]  mask_din;
    logic        inta;
    logic        eoi;
    logic        int_out;
    logic [3:0]  ack;
    logic [31:0] vector;
    logic        busy;
    logic [3:0]  mask;

    modport slave (
        input  req, mask_we, mask_din, inta, eoi,
        output int_out, ack, vector, busy, mask
    );

    modport master (
        output req, mask_we, mask_din, inta, eoi,
        input  int_out, ack, vector, busy, mask
    );
endinterface

// File: rtl/interrupt_arbiter.sv
// rtl/interrupt_arbiter.sv - 4-input interrupt arbiter, IDLE/PEND/ACK/SERVICE handshake
// Optional INTERRUPT_ARBITER_ROUND_ROBIN_EN replaces fixed lowest-index priority with rotating priority.
module interrupt_arbiter #(
    parameter logic [31:0] VECTOR_BASE = 32'h0000_0010
) (
    input  logic               clk,
    input  logic               rst,
    interrupt_arbiter_if.slave bus_if
);
    typedef enum logic [1:0] {IDLE, PEND, ACK, SERVICE} state_t;

    state_t     state_q, state_d;
    logic [1:0] winner_q, winner_d;
    logic [3:0] mask_q, mask_d;
    logic [3:0] eligible;
    logic [1:0] pick;

    assign eligible = bus_if.req & ~mask_q;

`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;

    // Search upward from the pointer, wrapping; first hit wins.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        pick  = ptr_q;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && eligible[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        pick = 2'd0;
        if (eligible[0])      pick = 2'd0;
        else if (eligible[1]) pick = 2'd1;
        else if (eligible[2]) pick = 2'd2;
        else if (eligible[3]) pick = 2'd3;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            winner_q <= 2'd0;
            mask_q   <= 4'b0000;
`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
            ptr_q    <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            mask_q   <= mask_d;
`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        mask_d   = bus_if.mask_we ? bus_if.mask_din : mask_q;
`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d  = PEND;
                    winner_d = pick;
                end
            end
            PEND: begin
                // An acknowledge on the same edge as a withdrawal still commits.
                if (bus_if.inta) begin
                    state_d = ACK;
`ifdef INTERRUPT_ARBITER_ROUND_ROBIN_EN
                    ptr_d   = winner_q + 2'd1;
`endif
                end else if (!eligible[winner_q]) begin
                    state_d = IDLE;
                end
            end
            ACK:     state_d = SERVICE;
            SERVICE: if (bus_if.eoi) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus_if.int_out = (state_q == PEND);
        bus_if.busy    = (state_q == SERVICE);
        bus_if.ack     = 4'b0000;
        bus_if.vector  = 32'h0;
        if (state_q == ACK) begin
            bus_if.ack    = 4'b0001 << winner_q;
            bus_if.vector = VECTOR_BASE + {30'd0, winner_q};
        end
    end

    assign bus_if.mask = mask_q;
endmodule
